// File: rtl/fifo_rd_pkg.sv
// Shared state encoding for the FIFO frame reader.
package fifo_rd_pkg;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_PRE   = 4'd1,
        S_READ  = 4'd2,
        S_DRAIN = 4'd3,
        S_DONE  = 4'd4,
        S_ABRT  = 4'd5
    } fr_state_t;

endpackage

// File: rtl/fifo_frame_read.sv
// Frame reader: pops a runtime-selected number of words from a 1-cycle-latency FIFO
// and packs them MSB-first into a wide result register.
module fifo_frame_read
    import fifo_rd_pkg::*;
#(
    parameter int DW    = 8,
    parameter int NWORD = 12,
    parameter int LW    = $clog2(NWORD + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fs,
    output logic                fd,
    input  logic                err,
    input  logic [LW-1:0]       frame_len,
    input  logic [DW-1:0]       fifo_rxd,
    input  logic                fifo_empty,
    output logic                fifo_rxen,
    output logic [NWORD*DW-1:0] res,
    output logic                res_vld,
    output logic                aborted,
    output logic [3:0]          state_fr
);

    localparam int RW = NWORD * DW;
    localparam int IW = $clog2(RW);
    localparam logic [LW-1:0] NW_L = LW'(NWORD);

    fr_state_t         r_state;
    logic              r_rxen_d;
    logic [LW-1:0]     r_rd_cnt;
    logic [LW-1:0]     r_wr_cnt;
    logic [LW-1:0]     r_len;
    logic              r_fd;
    logic              r_res_vld;
    logic              r_aborted;
    logic [RW-1:0]     r_res;

    logic              w_busy;
    logic              w_abort;
    logic              w_rxen;
    logic              w_cap;
    logic [IW-1:0]     w_lsb;

    assign w_busy  = (r_state == S_PRE) || (r_state == S_READ) || (r_state == S_DRAIN);
    assign w_abort = w_busy && err;
    // err suppresses the read in the same cycle so an aborted frame pops nothing more
    assign w_rxen  = (r_state == S_READ) && !fifo_empty && (r_rd_cnt < r_len) && !err;
    assign w_cap   = r_rxen_d && ((r_state == S_READ) || (r_state == S_DRAIN)) && !err
                     && (r_wr_cnt < r_len);
    assign w_lsb   = IW'((NWORD - 1 - int'(r_wr_cnt)) * DW);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_rxen_d  <= 1'b0;
            r_rd_cnt  <= '0;
            r_wr_cnt  <= '0;
            r_len     <= '0;
            r_fd      <= 1'b0;
            r_res_vld <= 1'b0;
            r_aborted <= 1'b0;
            r_res     <= '0;
        end else begin
            r_rxen_d <= w_rxen;
            if (w_cap) begin
                r_res[w_lsb +: DW] <= fifo_rxd;
                r_wr_cnt           <= r_wr_cnt + LW'(1);
            end
            if (w_rxen)
                r_rd_cnt <= r_rd_cnt + LW'(1);
            if (w_abort) begin
                r_state   <= S_ABRT;
                r_fd      <= 1'b1;
                r_aborted <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: if (fs) begin
                        r_state <= S_PRE;
                        r_len   <= (frame_len == '0 || frame_len > NW_L) ? NW_L : frame_len;
                    end
                    S_PRE: begin
                        r_rd_cnt  <= '0;
                        r_wr_cnt  <= '0;
                        r_res     <= '0;
                        r_res_vld <= 1'b0;
                        r_aborted <= 1'b0;
                        r_state   <= S_READ;
                    end
                    S_READ: if (w_rxen && (r_rd_cnt + LW'(1) == r_len))
                        r_state <= S_DRAIN;
                    S_DRAIN: if (r_wr_cnt == r_len) begin
                        r_state   <= S_DONE;
                        r_fd      <= 1'b1;
                        r_res_vld <= 1'b1;
                    end
                    S_DONE, S_ABRT: if (!fs) begin
                        r_state <= S_IDLE;
                        r_fd    <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_fd    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign fifo_rxen = w_rxen;
    assign fd        = r_fd;
    assign res       = r_res;
    assign res_vld   = r_res_vld;
    assign aborted   = r_aborted;
    assign state_fr  = r_state;

endmodule

// File: tb/tb_fifo_frame_read.sv
// Randomized bench for fifo_frame_read: FIFO models plus expected frames built from the stored words.
module tb_fifo_frame_read;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // instance A: DW=8, NWORD=12
    logic        a_fs, a_err, a_empty, a_rxen, a_fd, a_vld, a_abt, a_stall;
    logic [3:0]  a_fl, a_st;
    logic [7:0]  a_rxd;
    logic [95:0] a_res;
    logic [7:0]  a_mem [0:511];
    int          a_wp = 0, a_rp = 0, a_bad = 0;

    // instance B: DW=16, NWORD=4
    logic        b_fs, b_err, b_empty, b_rxen, b_fd, b_vld, b_abt;
    logic [2:0]  b_fl;
    logic [3:0]  b_st;
    logic [15:0] b_rxd;
    logic [63:0] b_res;
    logic [15:0] b_mem [0:511];
    int          b_wp = 0, b_rp = 0;

    fifo_frame_read #(.DW(8), .NWORD(12)) u_a (
        .clk(clk), .rst(rst), .fs(a_fs), .fd(a_fd), .err(a_err), .frame_len(a_fl),
        .fifo_rxd(a_rxd), .fifo_empty(a_empty), .fifo_rxen(a_rxen), .res(a_res),
        .res_vld(a_vld), .aborted(a_abt), .state_fr(a_st));

    fifo_frame_read #(.DW(16), .NWORD(4)) u_b (
        .clk(clk), .rst(rst), .fs(b_fs), .fd(b_fd), .err(b_err), .frame_len(b_fl),
        .fifo_rxd(b_rxd), .fifo_empty(b_empty), .fifo_rxen(b_rxen), .res(b_res),
        .res_vld(b_vld), .aborted(b_abt), .state_fr(b_st));

    // standard FIFOs: data appears the cycle after the read enable
    assign a_empty = a_stall || (a_rp == a_wp);
    assign b_empty = (b_rp == b_wp);

    always @(posedge clk) begin
        if (a_rxen) begin
            a_rxd <= a_mem[a_rp & 511];
            a_rp  <= a_rp + 1;
        end
        if (a_rxen && a_empty) a_bad <= a_bad + 1;
        if (b_rxen) begin
            b_rxd <= b_mem[b_rp & 511];
            b_rp  <= b_rp + 1;
        end
    end

    function automatic int eff(input int fl, input int nw);
        return (fl == 0 || fl > nw) ? nw : fl;
    endfunction

    function automatic logic [95:0] pack_a(input int start, input int n);
        logic [95:0] r = '0;
        for (int k = 0; k < n; k++)
            r = r | ({88'd0, a_mem[(start + k) & 511]} << ((11 - k) * 8));
        return r;
    endfunction

    function automatic logic [63:0] pack_b(input int start, input int n);
        logic [63:0] r = '0;
        for (int k = 0; k < n; k++)
            r = r | ({48'd0, b_mem[(start + k) & 511]} << ((3 - k) * 16));
        return r;
    endfunction

    task automatic push_a(input int n, input bit seq);
        for (int i = 0; i < n; i++) begin
            a_mem[a_wp & 511] = seq ? 8'(i + 1) : 8'($urandom);
            a_wp = a_wp + 1;
        end
    endtask

    task automatic push_b(input int n);
        for (int i = 0; i < n; i++) begin
            b_mem[b_wp & 511] = 16'($urandom);
            b_wp = b_wp + 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // raises fs and returns the number of edges after fs was sampled until fd; -1 on timeout
    task automatic run_a(input int fl, input bit rnd_stall, output int cyc);
        a_fl = 4'(fl);
        a_fs = 1'b1;
        cyc  = -1;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (a_fd) begin
                cyc = i;
                break;
            end
            if (rnd_stall) a_stall = ($urandom_range(0, 3) == 0);
        end
        a_stall = 1'b0;
    endtask

    task automatic run_b(input int fl, output int cyc);
        b_fl = 3'(fl);
        b_fs = 1'b1;
        cyc  = -1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (b_fd) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        tests++;
        if (a_st !== 4'd0 || a_fd !== 1'b0 || a_rxen !== 1'b0) begin
            fails++; $display("FAIL reset_a_ctrl: st=%0d fd=%b rxen=%b want 0 0 0", a_st, a_fd, a_rxen);
        end
        tests++;
        if (a_res !== '0 || a_vld !== 1'b0 || a_abt !== 1'b0) begin
            fails++; $display("FAIL reset_a_data: res=%h vld=%b abt=%b want 0", a_res, a_vld, a_abt);
        end
        tests++;
        if (b_st !== 4'd0 || b_fd !== 1'b0 || b_res !== '0 || b_vld !== 1'b0) begin
            fails++; $display("FAIL reset_b: st=%0d fd=%b res=%h vld=%b want 0", b_st, b_fd, b_res, b_vld);
        end
    endtask

    task automatic test_full_frame();
        int start, cyc;
        push_a(12, 1'b1);
        start = a_rp;
        run_a(12, 1'b0, cyc);
        tests++;
        if (cyc != 15) begin
            fails++; $display("FAIL full_latency: got %0d cycles want 15", cyc);
        end
        tests++;
        if (a_res !== 96'h0102030405060708090A0B0C || a_vld !== 1'b1) begin
            fails++; $display("FAIL full_res: res=%h vld=%b want 0102..0C 1", a_res, a_vld);
        end
        tests++;
        if (a_rp - start != 12) begin
            fails++; $display("FAIL full_pops: got %0d want 12", a_rp - start);
        end
        a_fs = 1'b0;
        tick();
        tests++;
        if (a_st !== 4'd0 || a_fd !== 1'b0 || a_vld !== 1'b1 || a_res !== 96'h0102030405060708090A0B0C) begin
            fails++; $display("FAIL full_release: st=%0d fd=%b vld=%b res=%h want 0 0 1 kept", a_st, a_fd, a_vld, a_res);
        end
    endtask

    task automatic test_stall();
        int start, cyc, rp_hold;
        bit seen;
        start = a_rp;
        push_a(3, 1'b0);
        a_fl = 4'd4;
        a_fs = 1'b1;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            tick();
            if (a_rp - start == 3) seen = 1;
        end
        rp_hold = a_rp;
        repeat (5) tick();
        tests++;
        if (!seen || a_rp != rp_hold || a_rxen !== 1'b0) begin
            fails++; $display("FAIL stall_hold: seen=%0d pops=%0d rxen=%b want 1 3 0", seen, a_rp - start, a_rxen);
        end
        push_a(1, 1'b0);
        cyc = -1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (a_fd) begin cyc = i; break; end
        end
        tests++;
        if (cyc < 0 || a_res !== pack_a(start, 4) || a_vld !== 1'b1) begin
            fails++; $display("FAIL stall_res: res=%h vld=%b want %h 1", a_res, a_vld, pack_a(start, 4));
        end
        tests++;
        if (a_bad != 0) begin
            fails++; $display("FAIL stall_rxen_empty: got %0d reads while empty want 0", a_bad);
        end
        a_fs = 1'b0;
        tick();
    endtask

    task automatic test_len_clamp();
        int start, cyc, fl;
        for (int j = 0; j < 2; j++) begin
            fl = (j == 0) ? 0 : 15;
            push_a(15, 1'b0);
            start = a_rp;
            run_a(fl, 1'b0, cyc);
            tests++;
            if (cyc != 15 || a_rp - start != 12 || a_res !== pack_a(start, 12)) begin
                fails++; $display("FAIL clamp_len%0d: cyc=%0d pops=%0d res=%h want 15 12 %h",
                                  fl, cyc, a_rp - start, a_res, pack_a(start, 12));
            end
            a_fs = 1'b0;
            tick();
        end
    endtask

    task automatic test_abort();
        int start, cyc;
        bit seen;
        push_a(12, 1'b0);
        start = a_rp;
        a_fl = 4'd12;
        a_fs = 1'b1;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            tick();
            if (a_rp - start == 6) seen = 1;
        end
        a_err = 1'b1;
        tick();
        a_err = 1'b0;
        tests++;
        if (!seen || a_st !== 4'd5 || a_fd !== 1'b1 || a_abt !== 1'b1 || a_vld !== 1'b0) begin
            fails++; $display("FAIL abort_state: seen=%0d st=%0d fd=%b abt=%b vld=%b want 1 5 1 1 0",
                              seen, a_st, a_fd, a_abt, a_vld);
        end
        repeat (3) tick();
        tests++;
        if (a_rp - start != 6) begin
            fails++; $display("FAIL abort_pops: got %0d want 6", a_rp - start);
        end
        tests++;
        if (a_res !== pack_a(start, 5)) begin
            fails++; $display("FAIL abort_res: got %h want %h", a_res, pack_a(start, 5));
        end
        a_fs = 1'b0;
        tick();
        tests++;
        if (a_st !== 4'd0 || a_fd !== 1'b0) begin
            fails++; $display("FAIL abort_release: st=%0d fd=%b want 0 0", a_st, a_fd);
        end
        start = a_rp;
        run_a(4, 1'b0, cyc);
        tests++;
        if (cyc != 7 || a_res !== pack_a(start, 4) || a_abt !== 1'b0 || a_vld !== 1'b1) begin
            fails++; $display("FAIL abort_next: cyc=%0d res=%h abt=%b vld=%b want 7 %h 0 1",
                              cyc, a_res, a_abt, a_vld, pack_a(start, 4));
        end
        a_fs = 1'b0;
        tick();
    endtask

    task automatic test_rst_mid();
        int rp_hold;
        push_a(12, 1'b0);
        a_fl = 4'd12;
        a_fs = 1'b1;
        repeat (6) tick();
        rst = 1'b1;
        #1;
        tests++;
        if (a_st !== 4'd0 || a_fd !== 1'b0 || a_rxen !== 1'b0 || a_res !== '0 || a_vld !== 1'b0 || a_abt !== 1'b0) begin
            fails++; $display("FAIL rst_mid: st=%0d fd=%b rxen=%b res=%h vld=%b want all 0",
                              a_st, a_fd, a_rxen, a_res, a_vld);
        end
        rp_hold = a_rp;
        repeat (3) tick();
        tests++;
        if (a_rp != rp_hold) begin
            fails++; $display("FAIL rst_reads: got %0d pops during reset want 0", a_rp - rp_hold);
        end
        a_fs = 1'b0;
        rst  = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int start, cyc, fl, n;
        for (int f = 0; f < 6; f++) begin
            push_a(12 + $urandom_range(0, 3), 1'b0);
            fl = $urandom_range(0, 15);
            n  = eff(fl, 12);
            start = a_rp;
            run_a(fl, 1'b1, cyc);
            tests++;
            if (cyc < 0 || a_rp - start != n || a_res !== pack_a(start, n) || a_vld !== 1'b1) begin
                fails++; $display("FAIL random_f%0d len%0d: cyc=%0d pops=%0d res=%h want %0d %h",
                                  f, fl, cyc, a_rp - start, a_res, n, pack_a(start, n));
            end
            a_err = 1'b1;
            tick();
            a_err = 1'b0;
            tests++;
            if (a_st !== 4'd4 || a_vld !== 1'b1 || a_abt !== 1'b0) begin
                fails++; $display("FAIL random_err_in_done: st=%0d vld=%b abt=%b want 4 1 0", a_st, a_vld, a_abt);
            end
            a_fs = 1'b0;
            tick();
        end
        tests++;
        if (a_bad != 0) begin
            fails++; $display("FAIL random_rxen_empty: got %0d want 0", a_bad);
        end
    endtask

    task automatic test_back_to_back();
        int start, cyc;
        push_b(8);
        start = b_rp;
        run_b(5, cyc);
        tests++;
        if (cyc != 7 || b_res !== pack_b(start, 4) || b_vld !== 1'b1) begin
            fails++; $display("FAIL b2b_first: cyc=%0d res=%h vld=%b want 7 %h 1", cyc, b_res, b_vld, pack_b(start, 4));
        end
        b_fs = 1'b0;
        tick();
        start = b_rp;
        b_fl = 3'd2;
        b_fs = 1'b1;
        tick();
        tick();
        tests++;
        if (b_st !== 4'd2 || b_vld !== 1'b0) begin
            fails++; $display("FAIL b2b_vld_drop: st=%0d vld=%b want 2 0", b_st, b_vld);
        end
        cyc = -1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (b_fd) begin cyc = i; break; end
        end
        tests++;
        if (cyc < 0 || b_res !== pack_b(start, 2) || b_vld !== 1'b1 || b_rp - start != 2) begin
            fails++; $display("FAIL b2b_second: res=%h vld=%b pops=%0d want %h 1 2",
                              b_res, b_vld, b_rp - start, pack_b(start, 2));
        end
        b_fs = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        a_fs = 1'b0; a_err = 1'b0; a_fl = '0; a_stall = 1'b0;
        b_fs = 1'b0; b_err = 1'b0; b_fl = '0;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        tick();
        test_full_frame();
        test_stall();
        test_len_clamp();
        test_abort();
        test_rst_mid();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1);
    end

endmodule
